mult_product_accumulator: RTL and testbench
===========================================

# mult_product_accumulator

Sequential accumulator placed directly downstream of the 2x2 bit-level multiplier. It takes each 4-bit product (P3..P0) under a valid/ready handshake and sums a programmable number of products into an ACC_W-bit result. It then presents the result on an output valid/ready handshake. This turns the combinational multiplier into a small multiply-accumulate path.

## Interface
- ACC_W, default 8: accumulator/result width; legal range 5..16.
- COUNT, default 4: products summed per result; legal range 1..255.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- P0, P1, P2, P3  in  1 each  product bits from the multiplier, P0 = LSB.
- in_valid  in  1  product bits are valid this cycle.
- in_ready  out  1  block accepts a product this cycle.
- flush  in  1  close the current result early.
- out_valid  out  1  result is available.
- out_ready  in  1  consumer takes the result.
- sum  out  ACC_W  accumulated result.
- cnt  out  8  number of products in the current or presented result.
- ovf  out  1  sticky overflow for the current result.

## Operation
- States:
  - IDLE: sum = 0, cnt = 0, ovf = 0.
  - ACC: accumulating products.
  - DONE: result is presented.
- in_ready = 1 in IDLE and ACC, 0 in DONE. out_valid = 1 only in DONE.
- Accept: a product is accepted when in_valid & in_ready. On acceptance:
  - sum <= sum + zero_ext({P3,P2,P1,P0}).
  - cnt <= cnt + 1.
  - ovf <= ovf | carry-out of the ACC_W-bit addition.
- Transitions:
  - IDLE -> ACC on an accept when COUNT > 1.
  - IDLE -> DONE on an accept when COUNT == 1.
  - ACC -> DONE on the accept that makes cnt == COUNT.
  - ACC -> DONE on flush.
  - DONE -> IDLE on out_valid & out_ready. sum, cnt and ovf clear on that same edge.
- Arithmetic: without saturation, sum wraps modulo 2^ACC_W.
- Flush rules:
  - flush in IDLE or DONE is ignored.
  - flush in ACC at the same edge as an accept: the product is included, then the state moves to DONE.
- In DONE, sum, cnt and ovf are held stable until the output handshake completes.
- in_valid while in_ready = 0: no effect. The upstream stage must hold its product.
- rst_n low at any edge: state goes to IDLE and all registers clear, including mid-ACC and mid-DONE. Any partial result is discarded.

## Timing
- Reset values:
  - in_ready = 1 (state IDLE).
  - out_valid = 0.
  - sum = 0, cnt = 0, ovf = 0.
- Latency: out_valid rises on the cycle after the clock edge that accepted the COUNT-th product (or the edge that sampled flush).
- Throughput: one product per cycle while accumulating.
- The cycle in DONE and the handshake cycle are bubbles. in_ready returns to 1 the cycle after the out handshake. Minimum result period is COUNT + 1 cycles.
- out_valid stays high with all outputs stable while out_ready = 0. It falls the cycle after out_ready is sampled high.
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.

## Configuration
- MULT_ACC_SAT_EN defined:
  - An addition that carries out sets sum to all-ones (2^ACC_W − 1) and sets ovf.
  - Later accepts keep sum at all-ones.
- MULT_ACC_SAT_EN undefined: wrap-around arithmetic as described above. ovf is still sticky.

## Test plan
- Defaults (ACC_W=8, COUNT=4): products 9, 9, 9, 9 on consecutive cycles with out_ready=1 -> out_valid one cycle after the 4th accept; sum=36, cnt=4, ovf=0; in_ready=1 the cycle after the handshake.
- ACC_W=5, COUNT=3, products 15, 15, 15:
  - Without the macro -> sum=13, ovf=1.
  - With MULT_ACC_SAT_EN -> sum=31, ovf=1.
- Flush: accept 6, then 3 with flush high on the same edge -> DONE; sum=9, cnt=2. A flush pulse in IDLE -> no state change.
- Backpressure: reach DONE, hold out_ready=0 for 3 cycles -> out_valid, sum, cnt and ovf stable; in_ready=0; products offered meanwhile are not accepted.
- Mid-operation reset: accept 2 products, drive rst_n=0 for one edge -> next cycle sum=0, cnt=0, ovf=0, out_valid=0, in_ready=1. A following 4-product run of 1s -> sum=4.
- Input gaps: COUNT=4, in_valid toggled 1,0,1,0,1,1 with product 2 -> exactly 4 accepts, sum=8, out_valid after the last accept.

Source files
------------

// File: rtl/mult_product_accumulator.sv
// Accumulates COUNT 4-bit multiplier products into an ACC_W-bit result behind valid/ready handshakes.
// Define MULT_ACC_SAT_EN to saturate the sum at all-ones on carry-out instead of wrapping.
module mult_product_accumulator #(
  parameter int unsigned ACC_W = 8,
  parameter int unsigned COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             P0,
  input  logic             P1,
  input  logic             P2,
  input  logic             P3,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic [7:0]       cnt,
  output logic             ovf
);

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic [3:0]         product;
  logic [ACC_W:0]     add_full;
  logic [7:0]         cnt_inc;
  logic               accept;
  logic               last;

  assign product  = {P3, P2, P1, P0};
  assign add_full = {1'b0, sum_q} + {{(ACC_W-3){1'b0}}, product};
  assign cnt_inc  = cnt_q + 8'd1;
  assign last     = (cnt_inc == 8'(COUNT));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    // in_ready is low in StDone, so accepts only happen in StIdle/StAcc
    if (accept) begin
`ifdef MULT_ACC_SAT_EN
      sum_d = add_full[ACC_W] ? '1 : add_full[ACC_W-1:0];
`else
      sum_d = add_full[ACC_W-1:0];
`endif
      cnt_d = cnt_inc;
      ovf_d = ovf_q | add_full[ACC_W];
    end

    unique case (state_q)
      StIdle: begin
        if (accept) state_d = last ? StDone : StAcc;
      end
      StAcc: begin
        if ((accept && last) || flush) state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
          sum_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q != StDone);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cnt       = cnt_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Bench for mult_product_accumulator: default instance (8-bit, COUNT=4) and a 5-bit COUNT=3 one.
module tb_mult_product_accumulator;

  typedef struct packed {
    logic [15:0] sum;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic [3:0] a_p;
  logic       a_in_valid, a_flush, a_out_ready;
  logic       a_in_ready, a_out_valid, a_ovf;
  logic [7:0] a_sum, a_cnt;

  logic [3:0] b_p;
  logic       b_in_valid, b_flush, b_out_ready;
  logic       b_in_ready, b_out_valid, b_ovf;
  logic [4:0] b_sum;
  logic [7:0] b_cnt;

  exp_t sb_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  mult_product_accumulator dut (
    .clk(clk), .rst_n(rst_n),
    .P0(a_p[0]), .P1(a_p[1]), .P2(a_p[2]), .P3(a_p[3]),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .sum(a_sum), .cnt(a_cnt), .ovf(a_ovf)
  );

  mult_product_accumulator #(.ACC_W(5), .COUNT(3)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .P0(b_p[0]), .P1(b_p[1]), .P2(b_p[2]), .P3(b_p[3]),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .sum(b_sum), .cnt(b_cnt), .ovf(b_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_p = '0; a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;
    b_p = '0; b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", a_in_ready);
    else n_pass++;
    n_checks++;
    if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", a_out_valid);
    else n_pass++;
    n_checks++;
    if ({a_sum, a_cnt, a_ovf} !== 17'd0)
      $display("FAIL reset_regs: got sum=%0d cnt=%0d ovf=%b want 0/0/0", a_sum, a_cnt, a_ovf);
    else n_pass++;
    n_checks++;
    if ({b_in_ready, b_out_valid, b_sum, b_cnt, b_ovf} !== {1'b1, 1'b0, 5'd0, 8'd0, 1'b0})
      $display("FAIL reset_dut5: got rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b",
               b_in_ready, b_out_valid, b_sum, b_cnt, b_ovf);
    else n_pass++;
  endtask

  task automatic test_basic();
    sb_q.push_back('{sum: 16'd36, cnt: 8'd4, ovf: 1'b0});
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_p         = 4'd9;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1)
        $display("FAIL basic_accepting[%0d]: got vld=%b rdy=%b want 0/1", i, a_out_valid,
                 a_in_ready);
      else n_pass++;
      tick();
    end
    a_in_valid = 1'b0;
    n_checks++;
    if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0)
      $display("FAIL basic_latency: got vld=%b rdy=%b want 1/0", a_out_valid, a_in_ready);
    else n_pass++;
    e = sb_q.pop_front();
    n_checks++;
    if (a_sum !== e.sum[7:0] || a_cnt !== e.cnt || a_ovf !== e.ovf)
      $display("FAIL basic_result: got %0d/%0d/%b want %0d/%0d/%b", a_sum, a_cnt, a_ovf,
               e.sum, e.cnt, e.ovf);
    else n_pass++;
    tick();
    n_checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_sum !== 8'd0 || a_cnt !== 8'd0)
      $display("FAIL basic_after_hs: got vld=%b rdy=%b sum=%0d cnt=%0d want 0/1/0/0",
               a_out_valid, a_in_ready, a_sum, a_cnt);
    else n_pass++;
  endtask

  task automatic test_overflow();
`ifdef MULT_ACC_SAT_EN
    sb_q.push_back('{sum: 16'd31, cnt: 8'd3, ovf: 1'b1});
`else
    sb_q.push_back('{sum: 16'd13, cnt: 8'd3, ovf: 1'b1});
`endif
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_p         = 4'd15;
    repeat (3) tick();
    b_in_valid = 1'b0;
    e = sb_q.pop_front();
    n_checks++;
    if (b_out_valid !== 1'b1 || b_sum !== e.sum[4:0] || b_cnt !== e.cnt || b_ovf !== e.ovf)
      $display("FAIL ovf_result: got vld=%b %0d/%0d/%b want 1 %0d/%0d/%b", b_out_valid, b_sum,
               b_cnt, b_ovf, e.sum, e.cnt, e.ovf);
    else n_pass++;
    tick();
    n_checks++;
    if (b_out_valid !== 1'b0 || b_sum !== 5'd0 || b_ovf !== 1'b0)
      $display("FAIL ovf_clear: got vld=%b sum=%0d ovf=%b want 0/0/0", b_out_valid, b_sum, b_ovf);
    else n_pass++;
  endtask

  task automatic test_flush();
    a_out_ready = 1'b0;
    a_flush     = 1'b1;
    a_in_valid  = 1'b0;
    tick();
    a_flush = 1'b0;
    n_checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_cnt !== 8'd0)
      $display("FAIL flush_idle: got rdy=%b vld=%b cnt=%0d want 1/0/0", a_in_ready, a_out_valid,
               a_cnt);
    else n_pass++;
    sb_q.push_back('{sum: 16'd9, cnt: 8'd2, ovf: 1'b0});
    a_in_valid = 1'b1;
    a_p        = 4'd6;
    tick();
    a_p     = 4'd3;
    a_flush = 1'b1;
    tick();
    a_in_valid = 1'b0;
    e = sb_q.pop_front();
    n_checks++;
    if (a_out_valid !== 1'b1 || a_sum !== e.sum[7:0] || a_cnt !== e.cnt || a_ovf !== e.ovf)
      $display("FAIL flush_result: got vld=%b %0d/%0d/%b want 1 %0d/%0d/%b", a_out_valid, a_sum,
               a_cnt, a_ovf, e.sum, e.cnt, e.ovf);
    else n_pass++;
    tick();
    a_flush = 1'b0;
    n_checks++;
    if (a_out_valid !== 1'b1 || a_cnt !== 8'd2)
      $display("FAIL flush_in_done: got vld=%b cnt=%0d want 1/2", a_out_valid, a_cnt);
    else n_pass++;
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    n_checks++;
    if (a_out_valid !== 1'b0) $display("FAIL flush_hs: got vld=%b want 0", a_out_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_p = 4'(i + 1);
      tick();
    end
    a_p = 4'd15;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({a_out_valid, a_in_ready, a_sum, a_cnt, a_ovf} !== {1'b1, 1'b0, 8'd10, 8'd4, 1'b0})
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b %0d/%0d/%b want 1/0 10/4/0", i,
                 a_out_valid, a_in_ready, a_sum, a_cnt, a_ovf);
      else n_pass++;
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    tick();
    n_checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_sum !== 8'd0)
      $display("FAIL bp_release: got vld=%b rdy=%b sum=%0d want 0/1/0", a_out_valid, a_in_ready,
               a_sum);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_p         = 4'd5;
    repeat (2) tick();
    a_in_valid = 1'b0;
    rst_n      = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if ({a_sum, a_cnt, a_ovf, a_out_valid, a_in_ready} !== {8'd0, 8'd0, 1'b0, 1'b0, 1'b1})
      $display("FAIL midrst_clear: got %0d/%0d/%b vld=%b rdy=%b want 0/0/0 0/1", a_sum, a_cnt,
               a_ovf, a_out_valid, a_in_ready);
    else n_pass++;
    sb_q.push_back('{sum: 16'd4, cnt: 8'd4, ovf: 1'b0});
    a_in_valid = 1'b1;
    a_p        = 4'd1;
    repeat (4) tick();
    a_in_valid = 1'b0;
    e = sb_q.pop_front();
    n_checks++;
    if (a_out_valid !== 1'b1 || a_sum !== e.sum[7:0] || a_cnt !== e.cnt)
      $display("FAIL midrst_rerun: got vld=%b %0d/%0d want 1 %0d/%0d", a_out_valid, a_sum, a_cnt,
               e.sum, e.cnt);
    else n_pass++;
    tick();
  endtask

  task automatic test_gaps();
    logic [5:0] pat;
    pat = 6'b110101;
    sb_q.push_back('{sum: 16'd8, cnt: 8'd4, ovf: 1'b0});
    a_out_ready = 1'b1;
    a_p         = 4'd2;
    for (int i = 0; i < 6; i++) begin
      a_in_valid = pat[i];
      if (i == 5) begin
        n_checks++;
        if (a_out_valid !== 1'b0 || a_cnt !== 8'd3)
          $display("FAIL gaps_early: got vld=%b cnt=%0d want 0/3", a_out_valid, a_cnt);
        else n_pass++;
      end
      tick();
    end
    a_in_valid = 1'b0;
    e = sb_q.pop_front();
    n_checks++;
    if (a_out_valid !== 1'b1 || a_sum !== e.sum[7:0] || a_cnt !== e.cnt)
      $display("FAIL gaps_result: got vld=%b %0d/%0d want 1 %0d/%0d", a_out_valid, a_sum, a_cnt,
               e.sum, e.cnt);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    bit m_done;
    int m_sum;
    int m_cnt;
    m_done = 1'b0;
    m_sum  = 0;
    m_cnt  = 0;
    for (int i = 0; i < 80; i++) begin
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_out_ready = ($urandom_range(0, 2) != 0);
      a_p         = 4'($urandom_range(0, 15));
      n_checks++;
      if (a_in_ready !== !m_done || a_out_valid !== m_done)
        $display("FAIL b2b_state[%0d]: got rdy=%b vld=%b want %b/%b", i, a_in_ready, a_out_valid,
                 !m_done, m_done);
      else n_pass++;
      if (m_done && a_out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL b2b_empty[%0d]: got empty scoreboard want entry", i);
        end else begin
          e = sb_q.pop_front();
          n_checks++;
          if (a_sum !== e.sum[7:0] || a_cnt !== e.cnt || a_ovf !== e.ovf)
            $display("FAIL b2b_result[%0d]: got %0d/%0d/%b want %0d/%0d/%b", i, a_sum, a_cnt,
                     a_ovf, e.sum, e.cnt, e.ovf);
          else n_pass++;
        end
      end
      if (a_in_valid && !m_done) begin
        m_sum += int'(a_p);
        m_cnt++;
        if (m_cnt == 4) begin
          sb_q.push_back('{sum: 16'(m_sum), cnt: 8'(m_cnt), ovf: 1'b0});
          m_done = 1'b1;
        end
      end else if (m_done && a_out_ready) begin
        m_done = 1'b0;
        m_sum  = 0;
        m_cnt  = 0;
      end
      tick();
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_flush();
    test_backpressure();
    test_mid_reset();
    test_gaps();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
